// File: rtl/micro_host_port_if.sv
// Host-side byte streams and the word-wide memory bus of micro_host_port.
// The slave modport is the port itself; the master modport is the host plus memory.
interface micro_host_port_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) ();
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output in_byte, in_valid, out_ready, mem_rdata,
        input  in_ready, out_byte, out_valid, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  in_byte, in_valid, out_ready, mem_rdata,
        output in_ready, out_byte, out_valid, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/micro_host_port.sv
// Byte-stream command decoder: turns host bytes into word writes/reads of a memory
// space, streams read data back little-endian, and drives core run/step control.
module micro_host_port #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    micro_host_port_if.slave   bus,
    output logic               core_run_o,
    output logic               core_step_o,
    output logic               busy_o
);
    localparam int unsigned AB  = (ADDR_W + 7) / 8;
    localparam int unsigned DB  = DATA_W / 8;
    localparam int unsigned AW8 = AB * 8;

    localparam logic [1:0] AddrLast = 2'(AB - 1);
    localparam logic [1:0] DataLast = 2'(DB - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAddr  = 3'd1;
    localparam logic [2:0] StWdata = 3'd2;
    localparam logic [2:0] StRreq  = 3'd3;
    localparam logic [2:0] StRwait = 3'd4;
    localparam logic [2:0] StRsend = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [AW8-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic              is_read_q, is_read_d;
    logic              we_q, we_d;
    logic              run_q, run_d;
    logic              step_q, step_d;
    logic              live_q;

    logic              in_acc, out_acc;
    logic [AW8+7:0]    addr_cat;
    logic [DATA_W+7:0] data_cat;
    logic [ADDR_W-1:0] addr_nxt;
    logic [AW8-1:0]    addr_incd;

    assign in_acc   = bus.in_valid & bus.in_ready;
    assign out_acc  = bus.out_valid & bus.out_ready;
    // Bytes shift in from the top so the first byte received ends up least significant.
    assign addr_cat = {bus.in_byte, addr_q};
    assign data_cat = {bus.in_byte, wdata_q};
    assign addr_nxt = addr_q[ADDR_W-1:0] + ADDR_W'(1);

    always_comb begin
        addr_incd               = addr_q;
        addr_incd[ADDR_W-1:0]   = addr_nxt;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        bcnt_d    = bcnt_q;
        is_read_d = is_read_q;
        run_d     = run_q;
        step_d    = 1'b0;
        we_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_acc) begin
                    case (bus.in_byte[7:6])
                        2'b01, 2'b10: begin
                            state_d   = StAddr;
                            is_read_d = bus.in_byte[7];
                            cnt_d     = bus.in_byte[5:0];
                            bcnt_d    = '0;
                        end
                        2'b11: begin
                            run_d  = bus.in_byte[0];
                            step_d = bus.in_byte[1] & ~bus.in_byte[0];
                        end
                        default: ;
                    endcase
                end
            end
            StAddr: begin
                if (in_acc) begin
                    addr_d = addr_cat[AW8+7:8];
                    if (bcnt_q == AddrLast) begin
                        bcnt_d  = '0;
                        state_d = is_read_q ? StRreq : StWdata;
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            StWdata: begin
                if (we_q) begin
                    // Strobe cycle: address and data held, advance afterwards.
                    addr_d = addr_incd;
                    if (cnt_q == 6'd0) state_d = StIdle;
                    else               cnt_d   = cnt_q - 6'd1;
                end else if (in_acc) begin
                    wdata_d = data_cat[DATA_W+7:8];
                    if (bcnt_q == DataLast) begin
                        bcnt_d = '0;
                        we_d   = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            StRreq:  state_d = StRwait;
            StRwait: begin
                rdata_d = bus.mem_rdata;
                state_d = StRsend;
            end
            StRsend: begin
                if (out_acc) begin
                    rdata_d = rdata_q >> 8;
                    if (bcnt_q == DataLast) begin
                        bcnt_d = '0;
                        addr_d = addr_incd;
                        if (cnt_q == 6'd0) begin
                            state_d = StIdle;
                        end else begin
                            cnt_d   = cnt_q - 6'd1;
                            state_d = StRreq;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            is_read_q <= 1'b0;
            we_q      <= 1'b0;
            run_q     <= 1'b0;
            step_q    <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            is_read_q <= is_read_d;
            we_q      <= we_d;
            run_q     <= run_d;
            step_q    <= step_d;
            live_q    <= 1'b1;
        end
    end

    // live_q keeps in_ready low until the first clock after reset release.
    assign bus.in_ready  = live_q & ~we_q &
                           ((state_q == StIdle) | (state_q == StAddr) | (state_q == StWdata));
    assign bus.out_valid = (state_q == StRsend);
    assign bus.out_byte  = rdata_q[7:0];
    assign bus.mem_addr  = addr_q[ADDR_W-1:0];
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_re    = (state_q == StRreq);
    assign core_run_o    = run_q;
    assign core_step_o   = step_q;
    assign busy_o        = (state_q != StIdle);
endmodule

// File: tb/tb_micro_host_port.sv
// Self-checking bench for micro_host_port (ADDR_W=8, DATA_W=16): scoreboarded writes
// and read bytes, a CTRL vector table, and hand-written reset/backpressure sequences.
module tb_micro_host_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic core_run, core_step, busy;

    micro_host_port_if #(.ADDR_W(8), .DATA_W(16)) mif ();

    micro_host_port #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (mif),
        .core_run_o  (core_run),
        .core_step_o (core_step),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    logic [23:0] exp_wq[$];
    logic [7:0]  exp_bq[$];
    logic [15:0] ref_mem[256];
    logic [15:0] mem[256];
    logic [15:0] wbuf[64];
    bit          mem_init_done = 1'b0;

    function automatic logic [15:0] seed(input int i);
        return 16'(i * 257) ^ 16'hA5C3;
    endfunction

    // Memory model: rdata is only meaningful the cycle after mem_re, noise otherwise.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
            mem_init_done <= 1'b1;
        end else if (mif.mem_we) begin
            mem[mif.mem_addr] <= mif.mem_wdata;
        end
        mif.mem_rdata <= mif.mem_re ? mem[mif.mem_addr] : 16'($urandom);
    end

    int         step_cnt = 0;
    logic       re_h1 = 1'b0, re_h2 = 1'b0, stall_q = 1'b0;
    logic [7:0] stall_byte = 8'h00;
    logic [23:0] e;
    logic [7:0]  eb;

    always @(negedge clk) begin
        if (!rst_n) begin
            re_h1   <= 1'b0;
            re_h2   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            if (mif.mem_we) begin
                check("we_in_ready_low", 32'(mif.in_ready), 32'd0);
                check("write_expected", 32'(exp_wq.size() != 0), 32'd1);
                if (exp_wq.size() != 0) begin
                    e = exp_wq.pop_front();
                    check("write_addr", 32'(mif.mem_addr), 32'(e[23:16]));
                    check("write_data", 32'(mif.mem_wdata), 32'(e[15:0]));
                end
            end
            if (re_h1) check("out_valid_low_t1", 32'(mif.out_valid), 32'd0);
            if (re_h2) check("out_valid_t2", 32'(mif.out_valid), 32'd1);
            if (stall_q) check("stall_hold", {23'd0, mif.out_valid, mif.out_byte},
                               {23'd0, 1'b1, stall_byte});
            if (mif.out_valid) check("in_ready_low_read", 32'(mif.in_ready), 32'd0);
            if (mif.out_valid && mif.out_ready) begin
                check("byte_expected", 32'(exp_bq.size() != 0), 32'd1);
                if (exp_bq.size() != 0) begin
                    eb = exp_bq.pop_front();
                    check("read_byte", 32'(mif.out_byte), 32'(eb));
                end
            end
            if (core_step) step_cnt <= step_cnt + 1;
            re_h2      <= re_h1;
            re_h1      <= mif.mem_re;
            stall_q    <= mif.out_valid & ~mif.out_ready;
            stall_byte <= mif.out_byte;
        end
    end

    // Call from posedge+1; the byte transfers on the edge after in_ready is seen high.
    task automatic send(input logic [7:0] b);
        int g = 0;
        mif.in_byte  = b;
        mif.in_valid = 1'b1;
        @(negedge clk);
        while (!mif.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("send_accepted", 32'(g < 200), 32'd1);
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit bp, output int cyc);
        int g = 0;
        while ((busy || exp_bq.size() != 0 || exp_wq.size() != 0) && g < 3000) begin
            @(posedge clk);
            #1;
            mif.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            g++;
        end
        mif.out_ready = 1'b1;
        check("done_in_time", 32'(g < 3000), 32'd1);
        check("writes_drained", 32'(exp_wq.size()), 32'd0);
        check("bytes_drained", 32'(exp_bq.size()), 32'd0);
        cyc = g;
    endtask

    task automatic do_write(input int n, input logic [7:0] addr);
        int cyc;
        logic [7:0] a;
        send({2'b01, 6'(n - 1)});
        send(addr);
        for (int w = 0; w < n; w++) begin
            a = addr + 8'(w);
            exp_wq.push_back({a, wbuf[w]});
            ref_mem[a] = wbuf[w];
            send(wbuf[w][7:0]);
            send(wbuf[w][15:8]);
        end
        wait_done(1'b0, cyc);
    endtask

    task automatic do_read(input int n, input logic [7:0] addr, input bit bp, output int cyc);
        logic [7:0] a;
        for (int w = 0; w < n; w++) begin
            a = addr + 8'(w);
            exp_bq.push_back(ref_mem[a][7:0]);
            exp_bq.push_back(ref_mem[a][15:8]);
        end
        send({2'b10, 6'(n - 1)});
        send(addr);
        wait_done(bp, cyc);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       run;
        logic       step;
    } ctrl_vec_t;

    ctrl_vec_t cv[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int s0;
        cv[0] = '{8'hC1, 1'b1, 1'b0};
        cv[1] = '{8'hC2, 1'b0, 1'b1};
        cv[2] = '{8'h00, 1'b0, 1'b0};
        cv[3] = '{8'hC3, 1'b1, 1'b0};
        cv[4] = '{8'h00, 1'b1, 1'b0};
        cv[5] = '{8'hC0, 1'b0, 1'b0};
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);

        // Reset with a byte offered: nothing may move.
        mif.in_byte   = 8'h40;
        mif.in_valid  = 1'b1;
        mif.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(mif.in_ready), 32'd0);
        check("rst_out_valid", 32'(mif.out_valid), 32'd0);
        check("rst_out_byte", 32'(mif.out_byte), 32'd0);
        check("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mif.mem_wdata), 32'd0);
        check("rst_mem_we_re", {30'd0, mif.mem_we, mif.mem_re}, 32'd0);
        check("rst_core", {30'd0, core_run, core_step}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        mif.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        #1 check("in_ready_before_clk", 32'(mif.in_ready), 32'd0);
        @(negedge clk);
        check("in_ready_after_release", 32'(mif.in_ready), 32'd1);
        @(posedge clk);
        #1;

        foreach (cv[i]) begin
            s0 = step_cnt;
            send(cv[i].cmd);
            check("ctrl_run", 32'(core_run), 32'(cv[i].run));
            check("ctrl_step_now", 32'(core_step), 32'(cv[i].step));
            repeat (3) @(posedge clk);
            #1;
            check("ctrl_step_count", 32'(step_cnt - s0), 32'(cv[i].step));
            check("ctrl_run_hold", 32'(core_run), 32'(cv[i].run));
        end

        wbuf[0] = 16'hAB34;
        do_write(1, 8'h12);
        do_read(1, 8'h12, 1'b0, cyc);
        check("read1_cycles", 32'(cyc), 32'd4);

        wbuf[0] = 16'hBEEF;
        wbuf[1] = 16'hC0DE;
        do_write(2, 8'hFF);
        do_read(2, 8'hFF, 1'b0, cyc);
        check("read2_cycles", 32'(cyc), 32'd8);

        do_read(3, 8'hFE, 1'b1, cyc);

        for (int w = 0; w < 5; w++) wbuf[w] = 16'($urandom);
        do_write(5, 8'h40);
        do_read(5, 8'h40, 1'b1, cyc);

        // Abort a write after one data byte; nothing may reach memory.
        send(8'h40);
        send(8'h05);
        send(8'h11);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(mif.mem_we), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_idle", 32'(busy), 32'd0);
        do_read(1, 8'h05, 1'b0, cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
